// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised asynchronous serial transmitter.
// Frames a parallel word as start bit, DATA_W data bits (MSB- or LSB-first),
// optional odd/even parity and one or two stop bits, with busy/done status.
module uart_tx_param #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              send,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration time
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (DATA_W < 5 || DATA_W > 16) begin : g_bad_width
        $error("uart_tx_param: DATA_W must be in 5..16");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              bit_end;
    logic              first_bit;
    logic [DATA_W-1:0] sh_next;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; txd_d is the line level of the bit being entered
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        par_d     = par_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_end   = (cnt_q == CNT_LAST);
        first_bit = (MSB_FIRST != 0) ? sh_q[DATA_W-1] : sh_q[0];
        sh_next   = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], 1'b0}
                                     : {1'b0, sh_q[DATA_W-1:1]};

        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (send) begin
                    state_d = S_START;
                    sh_d    = data;
                    par_d   = (PARITY == 1) ? ~(^data) : (^data);
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = first_bit;
                    sh_d    = sh_next;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        txd_d = first_bit;
                        sh_d  = sh_next;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        txd_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign txd  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param across several parameter sets.
module tb_uart_tx_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_v;
    logic [4:0]  send;
    wire  [4:0]  txd_w;
    wire  [4:0]  busy_w;
    wire  [4:0]  done_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 0: defaults, 4 clocks/bit
    uart_tx_param #(.CLKS_PER_BIT(4)) u_def (
        .clk(clk), .rst(rst), .data(data_v[7:0]), .send(send[0]),
        .txd(txd_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    // 1: even parity
    uart_tx_param #(.PARITY(2)) u_even (
        .clk(clk), .rst(rst), .data(data_v[7:0]), .send(send[1]),
        .txd(txd_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    // 2: odd parity
    uart_tx_param #(.PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .data(data_v[7:0]), .send(send[2]),
        .txd(txd_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    // 3: 5-bit, LSB first, two stop bits
    uart_tx_param #(.DATA_W(5), .MSB_FIRST(0), .STOP_BITS(2)) u_lsb (
        .clk(clk), .rst(rst), .data(data_v[4:0]), .send(send[3]),
        .txd(txd_w[3]), .busy(busy_w[3]), .done(done_w[3]));
    // 4: defaults, 2 clocks/bit, continuous send
    uart_tx_param #(.CLKS_PER_BIT(2)) u_cont (
        .clk(clk), .rst(rst), .data(data_v[7:0]), .send(send[4]),
        .txd(txd_w[4]), .busy(busy_w[4]), .done(done_w[4]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Accept a frame on instance idx and check every cycle of it plus the done cycle.
    // bits[nbits-1] is the first bit on the line. inj >= 0 pulses send with 8'h3C
    // at that cycle offset inside the frame.
    task automatic frame(input string tag, input int idx, input logic [15:0] bits,
                         input int nbits, input int cpb, input bit keep, input int inj);
        send[idx] = 1'b1;
        tick();
        if (!keep) send[idx] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < cpb; c++) begin
                int j;
                j = i * cpb + c;
                if (inj >= 0 && j == inj) begin
                    send[idx] = 1'b1;
                    data_v    = 16'h003C;
                end else if (inj >= 0 && j == inj + 1) begin
                    send[idx] = 1'b0;
                end
                chk($sformatf("%s txd bit%0d cyc%0d", tag, i, c), txd_w[idx], bits[nbits-1-i]);
                chk($sformatf("%s busy cyc%0d", tag, j), busy_w[idx], 1'b1);
                chk($sformatf("%s done cyc%0d", tag, j), done_w[idx], 1'b0);
                tick();
            end
        end
        chk({tag, " done pulse"}, done_w[idx], 1'b1);
        chk({tag, " busy low"}, busy_w[idx], 1'b0);
        chk({tag, " txd idle"}, txd_w[idx], 1'b1);
    endtask

    initial begin
        rst    = 1'b1;
        send   = '0;
        data_v = 16'h0000;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("reset txd u%0d", k), txd_w[k], 1'b1);
            chk($sformatf("reset busy u%0d", k), busy_w[k], 1'b0);
            chk($sformatf("reset done u%0d", k), done_w[k], 1'b0);
        end
        rst = 1'b0;
        tick();

        // Default frame: 0, A5 MSB first, stop
        data_v = 16'h00A5;
        frame("def_a5", 0, {6'd0, 1'b0, 8'hA5, 1'b1}, 10, 4, 1'b0, -1);
        tick();
        chk("def_a5 after done", done_w[0], 1'b0);

        // Parity variants
        data_v = 16'h0007;
        frame("even_07", 1, {5'd0, 1'b0, 8'h07, 1'b1, 1'b1}, 11, 1, 1'b0, -1);
        frame("odd_07", 2, {5'd0, 1'b0, 8'h07, 1'b0, 1'b1}, 11, 1, 1'b0, -1);
        data_v = 16'h0000;
        frame("even_00", 1, {5'd0, 1'b0, 8'h00, 1'b0, 1'b1}, 11, 1, 1'b0, -1);

        // LSB first, 5 bits, two stop bits: 0,1,0,0,0,0,1,1
        data_v = 16'h0001;
        frame("lsb_01", 3, 16'b0000_0000_0100_0011, 8, 1, 1'b0, -1);

        // Send during busy is ignored: A5 frame intact, no second frame
        tick();
        data_v = 16'h00A5;
        frame("busy_ign", 0, {6'd0, 1'b0, 8'hA5, 1'b1}, 10, 4, 1'b0, 20);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("busy_ign idle busy %0d", k), busy_w[0], 1'b0);
            chk($sformatf("busy_ign idle done %0d", k), done_w[0], 1'b0);
            chk($sformatf("busy_ign idle txd %0d", k), txd_w[0], 1'b1);
        end

        // Continuous send: three back-to-back frames, pitch 21 cycles
        data_v = 16'h00A5;
        frame("cont1", 4, {6'd0, 1'b0, 8'hA5, 1'b1}, 10, 2, 1'b1, -1);
        frame("cont2", 4, {6'd0, 1'b0, 8'hA5, 1'b1}, 10, 2, 1'b1, -1);
        frame("cont3", 4, {6'd0, 1'b0, 8'hA5, 1'b1}, 10, 2, 1'b0, -1);
        tick();
        chk("cont no 4th busy", busy_w[4], 1'b0);
        chk("cont no 4th txd", txd_w[4], 1'b1);

        // Reset during data bit 3 of A5
        data_v  = 16'h00A5;
        send[0] = 1'b1;
        tick();
        send[0] = 1'b0;
        repeat (16) tick();
        chk("rst_mid bit3 txd", txd_w[0], 1'b0);
        chk("rst_mid bit3 busy", busy_w[0], 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid txd", txd_w[0], 1'b1);
        chk("rst_mid busy", busy_w[0], 1'b0);
        chk("rst_mid done", done_w[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst_mid quiet done %0d", k), done_w[0], 1'b0);
            chk($sformatf("rst_mid quiet busy %0d", k), busy_w[0], 1'b0);
        end
        data_v = 16'h00FF;
        frame("post_rst_ff", 0, {6'd0, 1'b0, 8'hFF, 1'b1}, 10, 4, 1'b0, -1);

        // Reset and send together: reset wins
        tick();
        rst     = 1'b1;
        send[0] = 1'b1;
        tick();
        rst     = 1'b0;
        send[0] = 1'b0;
        chk("rst_send busy", busy_w[0], 1'b0);
        chk("rst_send txd", txd_w[0], 1'b1);
        tick();
        chk("rst_send busy later", busy_w[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
